// File: rtl/tone_player_if.sv
// Note-request channel: {max, dur} payload with a valid/ready handshake.
interface tone_player_if #(
  parameter int CNT_W = 17,
  parameter int DUR_W = 16
);
  logic [CNT_W-1:0] note_max;
  logic [DUR_W-1:0] note_dur;
  logic             note_valid;
  logic             note_ready;

  modport master (output note_max, note_dur, note_valid, input note_ready);
  modport slave  (input note_max, note_dur, note_valid, output note_ready);
endinterface

// File: rtl/tone_player.sv
// Queued square-wave tone generator: FIFO of {half-period, duration} requests,
// each played for dur ms on sclk_o, then followed by a silent gap.
module tone_player #(
  parameter int CNT_W      = 17,
  parameter int DUR_W      = 16,
  parameter int TICK_DIV   = 100000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_MS     = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  tone_player_if.slave                  req,
  input  logic                          enable_i,
  output logic                          sclk_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW  = $clog2(GAP_MS + 1);
  localparam int MSW = (DUR_W > GW) ? DUR_W : GW;
  localparam logic [AW:0]     DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [MSW-1:0]  GAP_C    = MSW'(GAP_MS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  div_q, div_d, cur_max_q, cur_max_d;
  logic [DUR_W-1:0]  cur_dur_q, cur_dur_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [MSW-1:0]    ms_q, ms_d, ms_nxt;
  logic              phase_q, phase_d, sclk_q, sclk_d;
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic [CNT_W+DUR_W-1:0] mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  head_max;
  logic [DUR_W-1:0]  head_dur;
  logic              push, pop, pre_wrap, fifo_nempty, fifo_multi;

  assign req.note_ready = (cnt_q < DEPTH_C);
  assign push        = req.note_valid && req.note_ready;
  assign pop         = (state_q == S_LOAD) && enable_i;
  assign fifo_nempty = (cnt_q != '0);
  assign fifo_multi  = (cnt_q > (AW+1)'(1));
  assign {head_max, head_dur} = mem_q[rd_q];
  assign pre_wrap    = (pre_q == PRE_LAST);
  assign ms_nxt      = ms_q + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {req.note_max, req.note_dur};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Everything holds while paused; sclk_d defaults low so pauses and non-PLAY states are silent.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pre_d     = pre_q;
    ms_d      = ms_q;
    cur_max_d = cur_max_q;
    cur_dur_d = cur_dur_q;
    phase_d   = phase_q;
    sclk_d    = 1'b0;
    if (enable_i) begin
      case (state_q)
        S_IDLE: if (fifo_nempty) state_d = S_LOAD;
        S_LOAD: begin
          cur_max_d = head_max;
          cur_dur_d = head_dur;
          div_d     = '0;
          pre_d     = '0;
          ms_d      = '0;
          phase_d   = 1'b0;
          if (head_dur == '0) state_d = fifo_multi ? S_LOAD : S_IDLE;
          else                state_d = S_PLAY;
        end
        S_PLAY: begin
          if (div_q == cur_max_q) begin
            div_d   = '0;
            phase_d = ~phase_q;
          end else begin
            div_d = div_q + 1'b1;
          end
          if (pre_wrap) begin
            pre_d = '0;
            ms_d  = ms_nxt;
          end else begin
            pre_d = pre_q + 1'b1;
          end
          if (pre_wrap && ms_nxt == MSW'(cur_dur_q)) begin
            ms_d = '0;
            if (GAP_MS == 0) state_d = fifo_nempty ? S_LOAD : S_IDLE;
            else             state_d = S_GAP;
          end else begin
            sclk_d = phase_d && (cur_max_q != '0);
          end
        end
        S_GAP: begin
          pre_d = pre_wrap ? '0 : pre_q + 1'b1;
          if (pre_wrap) ms_d = ms_nxt;
          if (pre_wrap && ms_nxt == GAP_C) begin
            ms_d    = '0;
            state_d = fifo_nempty ? S_LOAD : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      pre_q     <= '0;
      ms_q      <= '0;
      cur_max_q <= '0;
      cur_dur_q <= '0;
      phase_q   <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      cur_max_q <= cur_max_d;
      cur_dur_q <= cur_dur_d;
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign busy_o     = (state_q != S_IDLE) || fifo_nempty;
  assign fifo_cnt_o = cnt_q;
endmodule

// File: tb/tb_tone_player.sv
// Randomized bench for tone_player: a per-cycle reference model feeds a scoreboard
// that a separate monitor drains and compares against the DUT outputs.
module tb_tone_player;
  localparam int CW = 8, DW = 8, TD = 10, GAP = 1, DEP = 4;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic       sclk, busy;
  logic [2:0] fcnt;
  int         checks = 0, fails = 0;

  tone_player_if #(.CNT_W(CW), .DUR_W(DW)) bus();

  tone_player #(.CNT_W(CW), .DUR_W(DW), .TICK_DIV(TD), .FIFO_DEPTH(DEP), .GAP_MS(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .req(bus), .enable_i(enable),
    .sclk_o(sclk), .busy_o(busy), .fifo_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  typedef struct {int m; int d;} note_t;
  typedef struct packed {logic s; logic b; logic [2:0] c; logic r;} exp_t;

  // Model phases: 0 idle, 1 load, 2 play, 3 gap. m_t counts enabled clocks spent in the phase.
  note_t mq[$];
  exp_t  sb[$];
  int    m_ph = 0, m_t = 0, m_cm = 0, m_cd = 0;
  logic  m_s = 1'b0;

  task automatic model_edge();
    int sz;
    bit pushed;
    note_t n;
    exp_t e;
    if (rst) begin
      mq.delete(); sb.delete();
      m_ph = 0; m_t = 0; m_cm = 0; m_cd = 0; m_s = 1'b0;
      return;
    end
    sz = mq.size();
    pushed = bus.note_valid && (sz < DEP);
    m_s = 1'b0;
    if (enable) begin
      case (m_ph)
        0: if (sz > 0) m_ph = 1;
        1: begin
          n = mq.pop_front();
          m_cm = n.m; m_cd = n.d; m_t = 0;
          m_ph = (m_cd == 0) ? ((mq.size() > 0) ? 1 : 0) : 2;
        end
        2: begin
          m_t++;
          if (m_t == m_cd * TD) begin
            m_t = 0;
            m_ph = (GAP > 0) ? 3 : ((mq.size() > 0) ? 1 : 0);
          end else if (m_cm != 0) begin
            m_s = ((m_t / (m_cm + 1)) % 2) == 1;
          end
        end
        3: begin
          m_t++;
          if (m_t == GAP * TD) begin
            m_t = 0;
            m_ph = (mq.size() > 0) ? 1 : 0;
          end
        end
        default: m_ph = 0;
      endcase
    end
    if (pushed) begin
      n.m = int'(bus.note_max); n.d = int'(bus.note_dur);
      mq.push_back(n);
    end
    e.s = m_s;
    e.b = (m_ph != 0) || (mq.size() > 0);
    e.c = 3'(mq.size());
    e.r = mq.size() < DEP;
    sb.push_back(e);
  endtask

  always @(posedge clk or posedge rst) model_edge();

  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      a = {sclk, busy, fcnt, bus.note_ready};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_out t=%0t actual s=%b b=%b c=%0d r=%b required s=%b b=%b c=%0d r=%b",
                 $time, a.s, a.b, a.c, a.r, e.s, e.b, e.c, e.r);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push(input int m, input int d);
    @(negedge clk);
    bus.note_valid = 1'b1;
    bus.note_max   = CW'(m);
    bus.note_dur   = DW'(d);
    @(negedge clk);
    bus.note_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (m_ph == 0 && mq.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL wait_idle actual=timeout required=idle");
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.note_valid = 1'b0;
    bus.note_max   = '0;
    bus.note_dur   = '0;
    #2;
    chk("rst_sclk",  sclk, 0);
    chk("rst_cnt",   fcnt, 0);
    chk("rst_ready", bus.note_ready, 1);
    chk("rst_busy",  busy, 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;

    // single note
    push(2, 3);
    wait_idle();

    // fill FIFO while paused, fifth push refused
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push($urandom_range(1, 3), $urandom_range(1, 2));
    chk("full_ready", bus.note_ready, 0);
    chk("full_cnt",   fcnt, 4);
    enable = 1'b1;
    wait_idle();

    // rest, zero-duration, short note
    push(0, 2);
    push(1, 0);
    push(1, 1);
    wait_idle();

    // pause mid-play
    push(2, 3);
    repeat (12) @(negedge clk);
    enable = 1'b0;
    repeat (7) @(negedge clk);
    enable = 1'b1;
    wait_idle();

    // async reset mid-play with two entries queued
    push(1, 3);
    push(2, 2);
    push(3, 2);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sclk", sclk, 0);
    chk("arst_cnt",  fcnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("arst_busy", busy, 0);

    // push on the LOAD cycle with two queued
    enable = 1'b0;
    push(1, 2);
    push(2, 1);
    enable = 1'b1;
    @(negedge clk);
    bus.note_valid = 1'b1;
    bus.note_max   = CW'(3);
    bus.note_dur   = DW'(1);
    @(negedge clk);
    bus.note_valid = 1'b0;
    chk("pushpop_cnt", fcnt, 2);
    wait_idle();

    // randomized traffic with random pauses
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      enable         = ($urandom_range(0, 9) != 0);
      bus.note_valid = ($urandom_range(0, 5) == 0);
      bus.note_max   = CW'($urandom_range(0, 3));
      bus.note_dur   = DW'($urandom_range(0, 3));
    end
    @(negedge clk);
    bus.note_valid = 1'b0;
    enable = 1'b1;
    wait_idle();
    chk("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/tone_player.md
# tone_player

Parametrised, queued square-wave tone generator for the speaker PMOD. It accepts note requests over a valid/ready handshake and buffers them in a small FIFO. Each note plays as a square wave on `SCLK` for a programmed number of milliseconds, followed by an optional silent gap. It replaces the switch-driven fixed-divider path: a switch decoder or a sequencer upstream becomes a request producer, and `SCLK` drives the PMOD pin.

## Interface
- `CNT_W`, 17: width of the half-period count (`NOTE_MAX`) and of the divider counter.
- `DUR_W`, 16: width of the note duration in ms.
- `TICK_DIV`, 100000: system clocks per 1 ms tick (100 MHz board clock). Must be ≥ 2.
- `FIFO_DEPTH`, 4: request FIFO entries. Must be a power of 2 and ≥ 2.
- `GAP_MS`, 10: silent gap after each played note, in ms. 0 means no gap.
- `CLK`  in  1  system clock. All logic is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `NOTE_MAX`  in  CNT_W  half-period count. SCLK toggles every `NOTE_MAX+1` clocks. 0 means a rest.
- `NOTE_DUR`  in  DUR_W  note length in ms.
- `NOTE_VALID`  in  1  request valid.
- `NOTE_READY`  out  1  FIFO not full.
- `ENABLE`  in  1  1 = run; 0 = pause.
- `SCLK`  out  1  registered square-wave output to the PMOD.
- `BUSY`  out  1  asserted when state ≠ IDLE or the FIFO is non-empty.
- `FIFO_CNT`  out  clog2(FIFO_DEPTH)+1  number of entries occupied.

## Operation
- Push: a push occurs when `NOTE_VALID && NOTE_READY`. The pair {`NOTE_MAX`,`NOTE_DUR`} is written into the FIFO. `NOTE_READY` = (`FIFO_CNT` < `FIFO_DEPTH`), combinational from the count.
- Pop occurs only in LOAD. A push and a pop in the same cycle leave `FIFO_CNT` unchanged. The FIFO pointers wrap modulo `FIFO_DEPTH`.
- States: IDLE, LOAD, PLAY, GAP.
  - IDLE → LOAD when the FIFO is non-empty and `ENABLE`=1.
  - LOAD: pops the head entry and latches `cur_max`/`cur_dur`. It clears the divider counter, the ms prescaler and the ms counter.
    - `cur_dur`=0: the note is discarded with no gap. Next state is LOAD if the FIFO is still non-empty, else IDLE.
    - Otherwise → PLAY.
  - PLAY: the divider counter counts 0..`cur_max`. On reaching `cur_max` it wraps to 0 and toggles `SCLK`.
    - If `cur_max`=0 (rest), `SCLK` is held 0.
    - The prescaler counts 0..`TICK_DIV`-1. Each wrap increments the ms counter.
    - When the ms counter reaches `cur_dur`, the next state is GAP (counters cleared), or goes as after GAP when `GAP_MS`=0.
  - GAP: `SCLK`=0. It runs for `GAP_MS` ticks, then → LOAD if the FIFO is non-empty, else IDLE.
- `ENABLE`=0: all counters and the state freeze, and `SCLK` is forced to 0. The frozen `SCLK` phase is restored when `ENABLE` returns to 1. FIFO pushes continue to be accepted.
- `SCLK` is 0 in IDLE, LOAD and GAP. It is always driven from a flop, with no glitches.
- Width rules: the divider counter is `CNT_W` bits, the prescaler is clog2(`TICK_DIV`) bits, and the ms counter is max(`DUR_W`, clog2(`GAP_MS`+1)) bits. Counters never overflow because they compare with `==` before incrementing.

## Timing
- Reset values: state = IDLE, `SCLK`=0, `FIFO_CNT`=0, `NOTE_READY`=1, `BUSY`=0, all counters 0, FIFO contents don't-care.
- Reset mid-note: the FIFO is flushed, and `SCLK` goes to 0 immediately (asynchronously).
- Push to first `SCLK` rise, with the FIFO empty, IDLE and `ENABLE`=1:
  - Push edge: `FIFO_CNT` becomes 1.
  - Next edge: → LOAD.
  - Next edge: → PLAY.
  - `SCLK` then rises `NOTE_MAX`+1 clocks after PLAY entry.
- Square-wave period is 2·(`NOTE_MAX`+1) clocks at 50% duty.
- PLAY lasts exactly `NOTE_DUR`·`TICK_DIV` clocks, and GAP lasts exactly `GAP_MS`·`TICK_DIV` clocks (pauses excluded).
- Back-to-back notes: GAP → LOAD → PLAY adds 1 LOAD cycle between notes.
- `BUSY` falls in the cycle the state registers IDLE with the FIFO empty.

## Test plan
Bench parameters: `TICK_DIV`=10, `GAP_MS`=1, `FIFO_DEPTH`=4, `CNT_W`=8, `DUR_W`=8.

1. Single note: push {MAX=2, DUR=3}.
   - `SCLK` rises 3 clocks after PLAY entry and has period 6.
   - PLAY lasts 30 clocks, then `SCLK`=0 for 10 clocks.
   - The block returns to IDLE and `BUSY`=0.
2. Full FIFO: hold `ENABLE`=0 and push 5 requests.
   - Only 4 are accepted, and `NOTE_READY`=0 with `FIFO_CNT`=4.
   - Raise `ENABLE`: the notes play in push order, and `NOTE_READY` returns to 1 after the first pop.
3. Rest and zero-duration notes: push {MAX=0, DUR=2} then {MAX=1, DUR=0} then {MAX=1, DUR=1}.
   - `SCLK` stays 0 for 20 PLAY clocks plus the gap.
   - The DUR=0 entry is skipped with no gap.
   - The third note toggles with period 4 for 10 clocks.
4. Pause: drop `ENABLE` for 7 clocks mid-PLAY.
   - `SCLK`=0 during the pause.
   - The note's total active PLAY time is still 30 clocks, and the `SCLK` phase resumes where it stopped.
5. Async reset: assert `RST` mid-PLAY with 2 entries queued, between clock edges.
   - `SCLK`=0 and `FIFO_CNT`=0 immediately, with no further notes after release.
6. Simultaneous push/pop: push on the exact LOAD cycle with `FIFO_CNT`=2.
   - `FIFO_CNT` stays 2, and the data order is preserved.
